serial_adder_ctrl: RTL

Bit-serial adder controller that reuses a single 1-bit full adder to add two WIDTH-bit operands over WIDTH clock cycles. It holds the operand shift registers, the carry flip-flop and the bit counter. It sequences one full-adder evaluation per cycle, LSB first, and presents the registered result with a start/done handshake. It sits between a requester that owns the operands and the shared 1-bit full-adder datapath, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder_behavioral.sv | 13 +
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_adder_behavioral.sv
// Shared 1-bit full adder; the only arithmetic on operand data in the serial adder.
module full_adder_behavioral (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder evaluation per cycle, LSB first,
// with a start/ready/busy/done handshake and a held registered result.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, s_sh_reg, sum_reg;
    logic [WIDTH-1:0] s_shifted;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg;
    logic             sum_bit, carry_out, last_bit;

    full_adder_behavioral u_fa (
        .a         (a_sh_reg[0]),
        .b         (b_sh_reg[0]),
        .carry_in  (carry_reg),
        .sum       (sum_bit),
        .carry_out (carry_out)
    );

    // Written as shift-and-or so the same expression also holds for WIDTH=1.
    assign s_shifted = (s_sh_reg >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
    assign last_bit  = (cnt_reg == LAST);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        s_sh_reg  <= '0;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    s_sh_reg  <= s_shifted;
                    carry_reg <= carry_out;
                    cnt_reg   <= cnt_reg + CW'(1);
                    // Result registers only move on the completion edge.
                    if (last_bit) begin
                        sum_reg  <= s_shifted;
                        cout_reg <= carry_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
